// File: rtl/bcd_display_scanner.sv
// Four-digit BCD scanner feeding a single seven-segment decoder: double-buffered
// value, frame-aligned swaps, leading-zero and invalid-digit blanking, active-low anodes.
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic        load,
    input  logic [15:0] value,
    output logic        in3,
    output logic        in2,
    output logic        in1,
    output logic        in0,
    output logic        AN0,
    output logic        AN1,
    output logic        AN2,
    output logic        AN3,
    output logic [1:0]  digit_sel,
    output logic        pending,
    output logic        bad_bcd
);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [15:0]      r_shadow;
    logic [15:0]      r_active;
    logic             r_pending;
    logic             r_bad;
    logic [3:0]       r_in;
    logic [3:0]       r_an;

    logic             w_tick;
    logic             w_swap;
    logic [1:0]       w_sel_next;
    logic [15:0]      w_act_next;
    logic [3:0]       w_nib;
    logic [3:0]       w_lz;
    logic             w_blank;
    logic [3:0]       w_an_next;
    logic             w_bad;

    // Outputs are computed from the post-edge digit and active value so they
    // stay aligned with digit_sel and the frame swap.
    always_comb begin
        w_tick     = enable && (r_cnt == CNT_W'(REFRESH_DIV - 1));
        w_sel_next = w_tick ? r_sel + 2'd1 : r_sel;
        w_swap     = w_tick && (r_sel == 2'd3) && r_pending;
        w_act_next = w_swap ? r_shadow : r_active;
        w_nib      = w_act_next[{w_sel_next, 2'b00} +: 4];

        w_lz    = '0;
        w_lz[3] = (w_act_next[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (w_act_next[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (w_act_next[7:4] == 4'd0);

        w_blank   = (blank_lz && w_lz[w_sel_next]) || (w_nib > 4'd9);
        w_an_next = (enable && !w_blank) ? ~(4'b0001 << w_sel_next) : '1;

        w_bad = (r_active[15:12] > 4'd9) || (r_active[11:8] > 4'd9) ||
                (r_active[7:4] > 4'd9)   || (r_active[3:0] > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sel     <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_bad     <= 1'b0;
            r_in      <= '0;
            r_an      <= 4'b1110;
        end else begin
            if (enable)
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            r_sel    <= w_sel_next;
            r_active <= w_act_next;
            // A load on the swap edge refills the shadow, so pending stays set.
            if (load) begin
                r_shadow  <= value;
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_pending <= 1'b0;
            end
            r_bad <= w_bad;
            r_in  <= w_nib;
            r_an  <= w_an_next;
        end
    end

    assign {in3, in2, in1, in0} = r_in;
    assign {AN3, AN2, AN1, AN0} = r_an;
    assign digit_sel            = r_sel;
    assign pending              = r_pending;
    assign bad_bcd              = r_bad;

endmodule
